// File: rtl/adat_rx_scheduler_if.sv
// Bundle of receiver-side frame inputs, mixer-side stream and per-port status for adat_rx_scheduler.
// The slave modport is the scheduler; the master modport is the receivers plus mixer.
interface adat_rx_scheduler_if #(
    parameter int NUM_PORTS = 2
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]             frame_ready;
    logic [NUM_PORTS-1:0]             frame_valid;
    logic [NUM_PORTS-1:0][7:0][23:0]  frame_audio;
    logic                             out_valid;
    logic                             out_ready;
    logic [PW-1:0]                    out_port;
    logic [2:0]                       out_chan;
    logic signed [23:0]               out_sample;
    logic                             out_last;
    logic [NUM_PORTS-1:0]             locked;
    logic [NUM_PORTS-1:0]             overrun;
    logic [NUM_PORTS-1:0]             clr_overrun;

    modport master (
        output frame_ready, frame_valid, frame_audio, out_ready, clr_overrun,
        input  out_valid, out_port, out_chan, out_sample, out_last, locked, overrun
    );

    modport slave (
        input  frame_ready, frame_valid, frame_audio, out_ready, clr_overrun,
        output out_valid, out_port, out_chan, out_sample, out_last, locked, overrun
    );
endinterface

// File: rtl/adat_rx_scheduler.sv
// Buffers ADAT frames from NUM_PORTS receivers and streams them round-robin, one channel per beat.
// Optional ADAT_SCHED_MUTE_EN: frames captured while the port is not locked stream as zeros.
//
// state    | meaning
// S_IDLE   | no frame in flight; picks the next pending port from r_rr
// S_STREAM | presenting r_buf[r_sel][r_chan], advancing on out_ready
module adat_rx_scheduler #(
    parameter int NUM_PORTS      = 2,
    parameter int LOCK_FRAMES    = 4,
    parameter int TIMEOUT_CYCLES = 2560
) (
    input  logic                  clk,
    input  logic                  rst,
    adat_rx_scheduler_if.slave    bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]                      r_state;
    logic [PW-1:0]                   r_sel;
    logic [PW-1:0]                   r_rr;
    logic [2:0]                      r_chan;
    logic [NUM_PORTS-1:0]            r_pending;
    logic [NUM_PORTS-1:0]            r_mute;
    logic [NUM_PORTS-1:0]            r_locked;
    logic [NUM_PORTS-1:0]            r_overrun;
    logic [NUM_PORTS-1:0][7:0][23:0] r_buf;
    logic [NUM_PORTS-1:0][GW-1:0]    r_good;
    logic [NUM_PORTS-1:0][TW-1:0]    r_tmo;

    logic                            w_hs;
    logic                            w_done;
    logic [NUM_PORTS-1:0]            w_clr;
    logic [NUM_PORTS-1:0]            w_cap;
    logic [NUM_PORTS-1:0]            w_ovr;
    logic [NUM_PORTS-1:0][GW-1:0]    w_good_nxt;
    logic                            w_found;
    logic [PW-1:0]                   w_pick;
    logic [PW-1:0]                   w_cand;
    int                              w_idx;

    always_comb begin
        w_hs       = (r_state == S_STREAM) && bus.out_ready;
        w_done     = w_hs && (r_chan == 3'd7);
        w_clr      = '0;
        w_cap      = '0;
        w_ovr      = '0;
        w_good_nxt = r_good;
        for (int p = 0; p < NUM_PORTS; p++) begin
            // A port finishing its last beat this cycle may take a new frame immediately.
            w_clr[p] = w_done && (r_sel == PW'(p));
            w_cap[p] = bus.frame_ready[p] && bus.frame_valid[p] && (!r_pending[p] || w_clr[p]);
            w_ovr[p] = bus.frame_ready[p] && bus.frame_valid[p] && r_pending[p] && !w_clr[p];
            if (bus.frame_ready[p]) begin
                if (!bus.frame_valid[p])
                    w_good_nxt[p] = '0;
                else if (r_good[p] != GW'(LOCK_FRAMES))
                    w_good_nxt[p] = r_good[p] + 1'b1;
            end else if (r_tmo[p] == TW'(TIMEOUT_CYCLES - 1)) begin
                w_good_nxt[p] = '0;
            end
        end
    end

    // Cyclic search from r_rr; iterating downwards leaves the nearest pending port selected.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr;
        w_idx   = 0;
        w_cand  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            w_idx = int'(r_rr) + i;
            if (w_idx >= NUM_PORTS)
                w_idx = w_idx - NUM_PORTS;
            w_cand = PW'(w_idx);
            if (r_pending[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_rr      <= '0;
            r_chan    <= '0;
            r_pending <= '0;
            r_mute    <= '0;
            r_locked  <= '0;
            r_overrun <= '0;
            r_good    <= '0;
            r_tmo     <= '0;
        end else begin
            r_good <= w_good_nxt;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_cap[p])
                    r_pending[p] <= 1'b1;
                else if (w_clr[p])
                    r_pending[p] <= 1'b0;
`ifdef ADAT_SCHED_MUTE_EN
                if (w_cap[p])
                    r_mute[p] <= (w_good_nxt[p] != GW'(LOCK_FRAMES));
`else
                r_mute[p] <= 1'b0;
`endif
                r_overrun[p] <= w_ovr[p] || (r_overrun[p] && !bus.clr_overrun[p]);
                r_locked[p]  <= (w_good_nxt[p] == GW'(LOCK_FRAMES));
                if (bus.frame_ready[p])
                    r_tmo[p] <= '0;
                else if (r_tmo[p] != TW'(TIMEOUT_CYCLES))
                    r_tmo[p] <= r_tmo[p] + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_pick;
                        r_chan  <= '0;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_done) begin
                        r_rr    <= (r_sel == PW'(NUM_PORTS - 1)) ? '0 : r_sel + 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_hs) begin
                        r_chan <= r_chan + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sample storage carries no reset; pending flags decide what is meaningful.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_cap[p])
                r_buf[p] <= bus.frame_audio[p];
        end
    end

    assign bus.out_valid  = (r_state == S_STREAM);
    assign bus.out_port   = (r_state == S_STREAM) ? r_sel : '0;
    assign bus.out_chan   = (r_state == S_STREAM) ? r_chan : '0;
    assign bus.out_last   = (r_state == S_STREAM) && (r_chan == 3'd7);
    assign bus.out_sample = ((r_state == S_STREAM) && !r_mute[r_sel]) ? r_buf[r_sel][r_chan] : '0;
    assign bus.locked     = r_locked;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_adat_rx_scheduler.sv
// Bench for adat_rx_scheduler: random frame data, expected beat streams built from lock/mute and ordering rules.
// Inputs change 1 time unit after the rising edge; the beat monitor samples on the falling edge.
module tb_adat_rx_scheduler;
    localparam int NP = 2;
    localparam int LF = 4;
    localparam int TO = 2560;

    typedef struct {
        int          port;
        int          chan;
        logic [23:0] sample;
        logic        last;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   m_good [NP];
    logic [23:0] fdat [NP][8];
    beat_t got_q[$];
    beat_t exp_q[$];

    adat_rx_scheduler_if #(.NUM_PORTS(NP)) bus ();

    adat_rx_scheduler #(
        .NUM_PORTS(NP), .LOCK_FRAMES(LF), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready)
            got_q.push_back('{int'(bus.out_port), int'(bus.out_chan), bus.out_sample, bus.out_last, cyc});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.frame_ready = '0;
        bus.frame_valid = '0;
        bus.frame_audio = '0;
        bus.out_ready   = 1'b0;
        bus.clr_overrun = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int p = 0; p < NP; p++) m_good[p] = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic rand_port(input int p);
        for (int c = 0; c < 8; c++) fdat[p][c] = 24'($urandom);
    endtask

    task automatic strobe(input logic [NP-1:0] m, input logic [NP-1:0] v, output int s);
        bus.frame_ready = m;
        bus.frame_valid = v;
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 8; c++) bus.frame_audio[p][c] = fdat[p][c];
        s = cyc;
        tick();
        bus.frame_ready = '0;
        bus.frame_valid = '0;
        for (int p = 0; p < NP; p++) begin
            if (m[p]) m_good[p] = v[p] ? ((m_good[p] < LF) ? m_good[p] + 1 : LF) : 0;
        end
    endtask

    // Expected beats of a captured frame; first_cyc < 0 leaves beat timing unchecked.
    task automatic expect_frame(input int p, input int first_cyc);
        beat_t b;
        bit    mute;
`ifdef ADAT_SCHED_MUTE_EN
        mute = (m_good[p] != LF);
`else
        mute = 1'b0;
`endif
        for (int c = 0; c < 8; c++) begin
            b.port   = p;
            b.chan   = c;
            b.sample = mute ? 24'd0 : fdat[p][c];
            b.last   = (c == 7);
            b.cyc    = (first_cyc < 0) ? -1 : first_cyc + c;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int k = 0; k < budget && got_q.size() < n; k++) tick();
    endtask

    task automatic test_reset();
        reset_dut();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        n_tests++;
        if ({bus.out_port, bus.out_chan, bus.out_sample, bus.out_last} !== '0) begin
            n_fail++; $display("FAIL reset_beat got p%0d c%0d s%h l%b want all 0",
                bus.out_port, bus.out_chan, bus.out_sample, bus.out_last);
        end
        n_tests++;
        if (bus.locked !== '0) begin
            n_fail++; $display("FAIL reset_locked got %b want 0", bus.locked);
        end
        n_tests++;
        if (bus.overrun !== '0) begin
            n_fail++; $display("FAIL reset_overrun got %b want 0", bus.overrun);
        end
    endtask

    task automatic test_single_frame();
        int s;
        reset_dut();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) fdat[0][c] = 24'(c * 24'h010001);
        rand_port(1);
        strobe(2'b01, 2'b01, s);
        expect_frame(0, s + 2);
        wait_beats(8, 30);
        repeat (4) tick();
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i].port !== exp_q[i].port || got_q[i].chan !== exp_q[i].chan ||
                got_q[i].sample !== exp_q[i].sample || got_q[i].last !== exp_q[i].last ||
                got_q[i].cyc !== exp_q[i].cyc) begin
                n_fail++; $display("FAIL single_beat%0d got p%0d c%0d s%h l%b t%0d want p%0d c%0d s%h l%b t%0d", i,
                    got_q[i].port, got_q[i].chan, got_q[i].sample, got_q[i].last, got_q[i].cyc,
                    exp_q[i].port, exp_q[i].chan, exp_q[i].sample, exp_q[i].last, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_lock_timeout();
        int s;
        reset_dut();
        bus.out_ready = 1'b1;
        for (int k = 0; k < LF; k++) begin
            rand_port(0);
            strobe(2'b01, 2'b01, s);
            expect_frame(0, s + 2);
            n_tests++;
            if (bus.locked[0] !== (k == LF - 1)) begin
                n_fail++; $display("FAIL lock_after_strobe%0d got %b want %b", k + 1, bus.locked[0], (k == LF - 1));
            end
            if (k < LF - 1)
                while (cyc < s + 2048) tick();
        end
        while (cyc < s + TO) tick();
        n_tests++;
        if (bus.locked[0] !== 1'b1) begin
            n_fail++; $display("FAIL lock_before_timeout got %b want 1", bus.locked[0]);
        end
        tick();
        n_tests++;
        if (bus.locked[0] !== 1'b0) begin
            n_fail++; $display("FAIL lock_at_timeout got %b want 0", bus.locked[0]);
        end
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL lock_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i].port !== exp_q[i].port || got_q[i].chan !== exp_q[i].chan ||
                got_q[i].sample !== exp_q[i].sample || got_q[i].last !== exp_q[i].last ||
                got_q[i].cyc !== exp_q[i].cyc) begin
                n_fail++; $display("FAIL lock_beat%0d got p%0d c%0d s%h l%b t%0d want p%0d c%0d s%h l%b t%0d", i,
                    got_q[i].port, got_q[i].chan, got_q[i].sample, got_q[i].last, got_q[i].cyc,
                    exp_q[i].port, exp_q[i].chan, exp_q[i].sample, exp_q[i].last, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_backpressure();
        int s;
        reset_dut();
        bus.out_ready = 1'b1;
        rand_port(0);
        strobe(2'b01, 2'b01, s);
        expect_frame(0, s + 2);
        for (int c = 3; c < 8; c++) exp_q[c].cyc = exp_q[c].cyc + 5;
        repeat (4) tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_port !== 1'b0 || bus.out_chan !== 3'd3 ||
                bus.out_sample !== exp_q[3].sample || bus.out_last !== 1'b0) begin
                n_fail++; $display("FAIL stall%0d got v%b p%0d c%0d s%h l%b want v1 p0 c3 s%h l0", k,
                    bus.out_valid, bus.out_port, bus.out_chan, bus.out_sample, bus.out_last, exp_q[3].sample);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        wait_beats(8, 30);
        repeat (4) tick();
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i].port !== exp_q[i].port || got_q[i].chan !== exp_q[i].chan ||
                got_q[i].sample !== exp_q[i].sample || got_q[i].last !== exp_q[i].last ||
                got_q[i].cyc !== exp_q[i].cyc) begin
                n_fail++; $display("FAIL bp_beat%0d got p%0d c%0d s%h l%b t%0d want p%0d c%0d s%h l%b t%0d", i,
                    got_q[i].port, got_q[i].chan, got_q[i].sample, got_q[i].last, got_q[i].cyc,
                    exp_q[i].port, exp_q[i].chan, exp_q[i].sample, exp_q[i].last, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_round_robin();
        int s;
        reset_dut();
        bus.out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            rand_port(0);
            rand_port(1);
            strobe(2'b11, 2'b11, s);
            expect_frame(0, s + 2);
            expect_frame(1, s + 11);
            if (r == 0)
                while (cyc < s + 2048) tick();
        end
        wait_beats(32, 40);
        repeat (4) tick();
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rr_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i].port !== exp_q[i].port || got_q[i].chan !== exp_q[i].chan ||
                got_q[i].sample !== exp_q[i].sample || got_q[i].last !== exp_q[i].last ||
                got_q[i].cyc !== exp_q[i].cyc) begin
                n_fail++; $display("FAIL rr_beat%0d got p%0d c%0d s%h l%b t%0d want p%0d c%0d s%h l%b t%0d", i,
                    got_q[i].port, got_q[i].chan, got_q[i].sample, got_q[i].last, got_q[i].cyc,
                    exp_q[i].port, exp_q[i].chan, exp_q[i].sample, exp_q[i].last, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_overrun();
        int s;
        reset_dut();
        bus.out_ready = 1'b0;
        rand_port(0);
        strobe(2'b01, 2'b01, s);
        expect_frame(0, -1);
        tick();
        tick();
        n_tests++;
        if (bus.overrun[0] !== 1'b0) begin
            n_fail++; $display("FAIL ovr_before got %b want 0", bus.overrun[0]);
        end
        rand_port(0);
        strobe(2'b01, 2'b01, s);
        n_tests++;
        if (bus.overrun[0] !== 1'b1) begin
            n_fail++; $display("FAIL ovr_set got %b want 1", bus.overrun[0]);
        end
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_chan !== 3'd0 || bus.out_sample !== exp_q[0].sample) begin
            n_fail++; $display("FAIL ovr_hold got v%b c%0d s%h want v1 c0 s%h",
                bus.out_valid, bus.out_chan, bus.out_sample, exp_q[0].sample);
        end
        repeat (3) tick();
        bus.out_ready = 1'b1;
        wait_beats(8, 30);
        repeat (20) tick();
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL ovr_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i].port !== exp_q[i].port || got_q[i].chan !== exp_q[i].chan ||
                got_q[i].sample !== exp_q[i].sample || got_q[i].last !== exp_q[i].last) begin
                n_fail++; $display("FAIL ovr_beat%0d got p%0d c%0d s%h l%b want p%0d c%0d s%h l%b", i,
                    got_q[i].port, got_q[i].chan, got_q[i].sample, got_q[i].last,
                    exp_q[i].port, exp_q[i].chan, exp_q[i].sample, exp_q[i].last);
            end
        end
        bus.clr_overrun = 2'b01;
        tick();
        bus.clr_overrun = '0;
        n_tests++;
        if (bus.overrun[0] !== 1'b0) begin
            n_fail++; $display("FAIL ovr_clear got %b want 0", bus.overrun[0]);
        end
        // A clear landing on the same cycle as a new drop must leave the flag set.
        bus.out_ready = 1'b0;
        rand_port(0);
        strobe(2'b01, 2'b01, s);
        bus.clr_overrun = 2'b01;
        strobe(2'b01, 2'b01, s);
        bus.clr_overrun = '0;
        n_tests++;
        if (bus.overrun[0] !== 1'b1) begin
            n_fail++; $display("FAIL ovr_set_wins got %b want 1", bus.overrun[0]);
        end
    endtask

    task automatic test_invalid();
        int s;
        reset_dut();
        bus.out_ready = 1'b1;
        for (int k = 0; k < LF; k++) begin
            rand_port(1);
            strobe(2'b10, 2'b10, s);
            expect_frame(1, s + 2);
            repeat (12) tick();
        end
        n_tests++;
        if (bus.locked[1] !== 1'b1) begin
            n_fail++; $display("FAIL inv_locked got %b want 1", bus.locked[1]);
        end
        rand_port(1);
        strobe(2'b10, 2'b00, s);
        n_tests++;
        if (bus.locked[1] !== 1'b0) begin
            n_fail++; $display("FAIL inv_unlock got %b want 0", bus.locked[1]);
        end
        repeat (20) tick();
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL inv_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i].port !== exp_q[i].port || got_q[i].chan !== exp_q[i].chan ||
                got_q[i].sample !== exp_q[i].sample || got_q[i].last !== exp_q[i].last ||
                got_q[i].cyc !== exp_q[i].cyc) begin
                n_fail++; $display("FAIL inv_beat%0d got p%0d c%0d s%h l%b t%0d want p%0d c%0d s%h l%b t%0d", i,
                    got_q[i].port, got_q[i].chan, got_q[i].sample, got_q[i].last, got_q[i].cyc,
                    exp_q[i].port, exp_q[i].chan, exp_q[i].sample, exp_q[i].last, exp_q[i].cyc);
            end
        end
        got_q.delete();
        exp_q.delete();
        rand_port(0);
        strobe(2'b01, 2'b01, s);
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_valid got %b want 0", bus.out_valid);
        end
        rst = 1'b0;
        for (int p = 0; p < NP; p++) m_good[p] = 0;
        repeat (20) tick();
        n_tests++;
        if (got_q.size() !== 1 || got_q[0].chan !== 0 || got_q[0].last !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_beats got %0d beats want 1 beat on chan 0 without last", got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_lock_timeout();
        test_backpressure();
        test_round_robin();
        test_overrun();
        test_invalid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/adat_rx_scheduler.md
# adat_rx_scheduler

Shares the mixer's single ingest port between `NUM_PORTS` ADAT receivers. Each receiver delivers a parallel 8×24-bit frame with a one-cycle strobe. This block:
- latches each frame into a per-port holding buffer;
- tracks lock per port;
- serialises pending frames round-robin onto one channel-sequential valid/ready stream feeding the mixer core.

It runs in the 98.304 MHz receiver domain. Frame period at 48 kHz is 2048 cycles.

## Interface
Parameters:
- `NUM_PORTS`, default 2: number of receivers, range 1–8.
- `LOCK_FRAMES`, default 4: consecutive valid frames required to declare lock.
- `TIMEOUT_CYCLES`, default 2560: cycles without any `frame_ready` before lock is dropped.

Ports:
- `clk`  in  1  clock; `rst`  in  1  reset, synchronous, active-high.
- `frame_ready`  in  `NUM_PORTS`  per-port one-cycle frame strobe.
- `frame_valid`  in  `NUM_PORTS`  per-port frame integrity flag, qualified by `frame_ready`.
- `frame_audio`  in  [`NUM_PORTS`][8]×24 signed  per-port channel samples, qualified by `frame_ready`.
- `out_valid`  out  1  stream beat valid.
- `out_ready`  in  1  mixer accepts beat.
- `out_port`  out  clog2(`NUM_PORTS`), min 1  source port of beat.
- `out_chan`  out  3  channel index 0–7.
- `out_sample`  out  24 signed  sample.
- `out_last`  out  1  high on channel-7 beat.
- `locked`  out  `NUM_PORTS`  per-port lock status.
- `overrun`  out  `NUM_PORTS`  sticky dropped-frame flag.
- `clr_overrun`  in  `NUM_PORTS`  one-cycle clear of the matching `overrun` bits.

## Operation
**Reset**
- All outputs are 0.
- All pending flags, lock counters, timeout counters, the round-robin pointer `rr_ptr` and the FSM state are cleared. FSM state resets to IDLE.

**Capture** (per port p, on a cycle with `frame_ready[p]=1` and `frame_valid[p]=1`):
- If `pending[p]=0`, or `pending[p]` is being cleared this same cycle (last beat of p accepted): store all 8 samples, set `pending[p]`, and latch `mute[p]` (see Configuration).
- Otherwise keep the old buffer, drop the new frame, and set `overrun[p]`.
- If a set and a `clr_overrun` coincide, the set wins.

**Lock** (per port, saturating counter `good`, 0..`LOCK_FRAMES`):
- Valid strobe: `good` increments.
- Strobe with `frame_valid=0`: `good` goes to 0. The frame is not captured.
- Timeout counter: reset on any `frame_ready`, otherwise increments. On reaching `TIMEOUT_CYCLES`, `good` goes to 0 and the counter holds until the next strobe.
- `locked[p]` is registered as (`good==LOCK_FRAMES`).

**Scheduler FSM**
- IDLE: if any pending, select the first pending port at or after `rr_ptr` (cyclic search), latch `sel`, set chan to 0, go to STREAM.
- STREAM: `out_valid=1`, `out_port=sel`, `out_chan=chan`, `out_sample=buf[sel][chan]` (0 if muted), `out_last=(chan==7)`.
  - On handshake with chan<7: chan increments.
  - On handshake with chan==7: clear `pending[sel]`, set `rr_ptr=(sel+1) mod NUM_PORTS`, go to IDLE.
- The buffer of a port being streamed is never overwritten. A frame arriving mid-stream on that port is an overrun, except on the final-beat cycle.

## Timing
- Capture: strobe sampled at edge T; `pending` and `locked` are visible after T.
- Latency from an idle scheduler: first beat (`out_valid`) appears after edge T+1, i.e. 2 cycles after the strobe cycle.
- Throughput: with `out_ready=1`, 8 beats on consecutive cycles, then 1 IDLE bubble. Minimum 9 cycles per frame.
- Backpressure: `out_port`, `out_chan`, `out_sample` and `out_last` stay stable while `out_valid && !out_ready`. The channel count never skips.
- Reset mid-frame: `out_valid` is 0 after the reset edge. The partial frame is discarded and no `out_last` is emitted.
- `NUM_PORTS=1`: `out_port` is always 0 and round-robin is trivial.

## Configuration
- `ADAT_SCHED_MUTE_EN` defined: `mute[p]` is latched at capture as NOT(`good` after this frame == `LOCK_FRAMES`). Every beat of a muted frame carries `out_sample=0`; `out_port`, `out_chan` and `out_last` are unchanged.
- Undefined: `mute` is tied to 0. Samples always pass through; `locked` is status only.

## Test plan
- **Single frame.** Port 0, one valid strobe, samples c×24'h010001, `out_ready=1`.
  - Expect 8 beats starting 2 cycles after the strobe, chan 0–7, samples 24'h000000…24'h070007, `out_last` only on chan 7.
- **Lock and timeout.** Port 0, valid strobes every 2048 cycles.
  - `locked[0]=1` the cycle after the 4th strobe.
  - Stop strobes: `locked[0]=0` 2560 cycles after the last strobe.
  - With MUTE_EN: frames 1–3 stream zeros and frame 4 streams data.
- **Backpressure.** `out_ready=0` for 5 cycles while chan=3 is presented.
  - Outputs stay stable; chan 3–7 are delivered after release with no loss or duplication.
- **Round-robin.** Ports 0 and 1 strobe in the same cycle, twice at 2048-cycle spacing.
  - Each time: port 0's 8 beats, 1 bubble, then port 1's 8 beats. `rr_ptr` wraps to 0.
- **Overrun.** `out_ready=0`, two valid strobes on port 0.
  - `overrun[0]=1`; the first frame's data streams after release; the second frame never appears.
  - `clr_overrun[0]` pulse clears the flag.
- **Invalid frame.** Locked port 1 receives a strobe with `frame_valid=0`.
  - No beats are emitted and `locked[1]=0` the next cycle.
  - A `rst` pulse mid-stream drops `out_valid` after that edge.
